// File: rtl/op_sequencer_if.sv
// Bundle of operand stream, result stream and compute-core request signals
// used between host logic, op_sequencer and the start/busy compute core.
interface op_sequencer_if;
  logic        op_valid;
  logic [15:0] op_data;
  logic        op_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_ready;
  logic        req_st;
  logic [15:0] req_in;
  logic        req_busy;
  logic [31:0] req_out;
  logic        inflight;

  // master: host side plus compute core; slave: the sequencer itself
  modport master (
    output op_valid, op_data, res_ready, req_busy, req_out,
    input  op_ready, res_valid, res_data, res_err, req_st, req_in, inflight
  );

  modport slave (
    input  op_valid, op_data, res_ready, req_busy, req_out,
    output op_ready, res_valid, res_data, res_err, req_st, req_in, inflight
  );
endinterface

// File: rtl/op_sequencer.sv
// Operand FIFO -> one-at-a-time start/busy request -> in-order result FIFO.
// Optional WATCHDOG_EN bounds WAIT to TIMEOUT cycles and flags timed-out results.
module op_sequencer #(
  parameter int OP_DEPTH  = 4,
  parameter int RES_DEPTH = 4,
  parameter int BUSY_LAT  = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic          clk,
  input  logic          rst,
  op_sequencer_if.slave bus
);

  localparam int OP_AW   = $clog2(OP_DEPTH);
  localparam int RES_AW  = $clog2(RES_DEPTH);
  // one counter serves both the ARM countdown and the WAIT watchdog
  localparam int CNT_MAX = (TIMEOUT > BUSY_LAT) ? TIMEOUT : BUSY_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_CAPTURE} state_t;

  state_t r_state, w_state_next;

  logic [15:0]       r_op_mem [OP_DEPTH];
  logic [OP_AW-1:0]  r_op_wr, r_op_rd;
  logic [OP_AW:0]    r_op_cnt;

  logic [31:0]       r_res_mem [RES_DEPTH];
  logic [RES_AW-1:0] r_res_wr, r_res_rd;
  logic [RES_AW:0]   r_res_cnt;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_st;
  logic [15:0]       r_req_in;
  logic              r_inflight;

  logic w_op_ready, w_op_push, w_op_pop, w_op_empty;
  logic w_res_full, w_res_empty, w_res_push, w_res_pop;
  logic w_launch, w_capture, w_timed_out;
  logic [31:0] w_push_data;

  assign w_op_empty  = (r_op_cnt == '0);
  assign w_op_ready  = (r_op_cnt != (OP_AW+1)'(OP_DEPTH));
  assign w_op_push   = bus.op_valid & w_op_ready;
  assign w_op_pop    = w_launch;

  assign w_res_empty = (r_res_cnt == '0);
  assign w_res_full  = (r_res_cnt == (RES_AW+1)'(RES_DEPTH));
  assign w_res_push  = w_capture;
  assign w_res_pop   = ~w_res_empty & bus.res_ready;

`ifdef WATCHDOG_EN
  assign w_timed_out = (r_cnt == CNT_W'(TIMEOUT));
`else
  assign w_timed_out = 1'b0;
`endif
  assign w_push_data = w_timed_out ? 32'hFFFF_FFFF : bus.req_out;

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_op_empty && !w_res_full) begin
          w_launch     = 1'b1;
          w_state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (r_cnt <= CNT_W'(1)) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.req_busy) w_state_next = S_CAPTURE;
`ifdef WATCHDOG_EN
        else if (r_cnt == CNT_W'(TIMEOUT - 1)) w_state_next = S_CAPTURE;
`endif
      end
      S_CAPTURE: begin
        w_capture    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_st   <= 1'b0;
      r_req_in   <= '0;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_req_st <= w_launch;
      if (w_launch) begin
        r_req_in   <= r_op_mem[r_op_rd];
        r_inflight <= 1'b1;
        r_cnt      <= CNT_W'(BUSY_LAT);
      end else if (r_state == S_ARM) begin
        r_cnt <= (w_state_next == S_WAIT) ? '0 : r_cnt - CNT_W'(1);
      end
`ifdef WATCHDOG_EN
      else if (r_state == S_WAIT && bus.req_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
`endif
      if (w_capture) r_inflight <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; storage itself is never reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_wr   <= '0;
      r_op_rd   <= '0;
      r_op_cnt  <= '0;
      r_res_wr  <= '0;
      r_res_rd  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_op_push) r_op_wr <= r_op_wr + OP_AW'(1);
      if (w_op_pop)  r_op_rd <= r_op_rd + OP_AW'(1);
      case ({w_op_push, w_op_pop})
        2'b10:   r_op_cnt <= r_op_cnt + (OP_AW+1)'(1);
        2'b01:   r_op_cnt <= r_op_cnt - (OP_AW+1)'(1);
        default: r_op_cnt <= r_op_cnt;
      endcase
      if (w_res_push) r_res_wr <= r_res_wr + RES_AW'(1);
      if (w_res_pop)  r_res_rd <= r_res_rd + RES_AW'(1);
      case ({w_res_push, w_res_pop})
        2'b10:   r_res_cnt <= r_res_cnt + (RES_AW+1)'(1);
        2'b01:   r_res_cnt <= r_res_cnt - (RES_AW+1)'(1);
        default: r_res_cnt <= r_res_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_op_push)  r_op_mem[r_op_wr]   <= bus.op_data;
    if (w_res_push) r_res_mem[r_res_wr] <= w_push_data;
  end

`ifdef WATCHDOG_EN
  logic r_res_err_mem [RES_DEPTH];

  always_ff @(posedge clk) begin
    if (w_res_push) r_res_err_mem[r_res_wr] <= w_timed_out;
  end

  assign bus.res_err = w_res_empty ? 1'b0 : r_res_err_mem[r_res_rd];
`else
  assign bus.res_err = 1'b0;
`endif

  assign bus.op_ready  = w_op_ready;
  assign bus.res_valid = ~w_res_empty;
  assign bus.res_data  = w_res_empty ? 32'd0 : r_res_mem[r_res_rd];
  assign bus.req_st    = r_req_st;
  assign bus.req_in    = r_req_in;
  assign bus.inflight  = r_inflight;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer with a start/busy responder model.
// The watchdog scenario is compiled in only when WATCHDOG_EN is defined.
module tb_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  op_sequencer_if bus();

  op_sequencer #(
    .OP_DEPTH (4),
    .RES_DEPTH(4),
    .BUSY_LAT (1),
    .TIMEOUT  (50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // responder configuration: busy for rsp_lat cycles, out = in*mul + add
  int          rsp_lat  = 20;
  logic [31:0] rsp_mul  = 32'd0;
  logic [31:0] rsp_add  = 32'd7;
  logic        rsp_hold = 1'b0;
  logic        rsp_init = 1'b1;
  int          rsp_cnt  = 0;

  always @(posedge clk) begin
    if (rsp_init) begin
      bus.req_busy <= 1'b0;
      bus.req_out  <= 32'd0;
      rsp_cnt      <= 0;
    end else if (bus.req_st) begin
      bus.req_busy <= 1'b1;
      rsp_cnt      <= rsp_lat;
      bus.req_out  <= {16'd0, bus.req_in} * rsp_mul + rsp_add;
    end else if (!rsp_hold) begin
      if (rsp_cnt > 1) rsp_cnt <= rsp_cnt - 1;
      else if (rsp_cnt == 1) begin
        bus.req_busy <= 1'b0;
        rsp_cnt      <= 0;
      end
    end
  end

  // monitor: cycle count, start-pulse log, pulse width and busy overlap
  int          cyc    = 0;
  int          st_cyc = 0;
  int          dbl_st = 0;
  int          ovl    = 0;
  logic        prev_st = 1'b0;
  logic [15:0] st_log[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && bus.req_st) begin
      st_log.push_back(bus.req_in);
      st_cyc = cyc;
      if (prev_st) dbl_st = dbl_st + 1;
      if (bus.req_busy) ovl = ovl + 1;
      $display("[%0d] start pulse req_in=%0d", cyc, bus.req_in);
    end
    prev_st = bus.req_st;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic [15:0] d, output int waited);
    waited = 0;
    bus.op_valid = 1'b1;
    bus.op_data  = d;
    while (!bus.op_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("push accepted", {31'd0, bus.op_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    $display("push op=%0d waited=%0d", d, waited);
  endtask

  task automatic wait_res();
    int t = 0;
    while (!bus.res_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d, input logic e);
    wait_res();
    chk({tag, " valid"}, {31'd0, bus.res_valid}, 32'd1);
    chk({tag, " data"}, bus.res_data, d);
    chk({tag, " err"}, {31'd0, bus.res_err}, {31'd0, e});
    $display("pop %s data=%0h err=%0d", tag, bus.res_data, bus.res_err);
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " op_ready"},  {31'd0, bus.op_ready},  32'd1);
    chk({tag, " res_valid"}, {31'd0, bus.res_valid}, 32'd0);
    chk({tag, " res_data"},  bus.res_data,           32'd0);
    chk({tag, " res_err"},   {31'd0, bus.res_err},   32'd0);
    chk({tag, " req_st"},    {31'd0, bus.req_st},    32'd0);
    chk({tag, " req_in"},    {16'd0, bus.req_in},    32'd0);
    chk({tag, " inflight"},  {31'd0, bus.inflight},  32'd0);
  endtask

  initial begin
    int w;
    int base;
    int t;
    bus.op_valid  = 1'b0;
    bus.op_data   = 16'd0;
    bus.res_ready = 1'b0;

    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rsp_init = 1'b0;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // single op: in=2, busy 20 cycles, out=7
    rsp_lat = 20; rsp_mul = 32'd0; rsp_add = 32'd7;
    base = st_log.size();
    push_op(16'd2, w);
    @(negedge clk);
    chk("single st high", {31'd0, bus.req_st}, 32'd1);
    chk("single req_in", {16'd0, bus.req_in}, 32'd2);
    chk("single inflight", {31'd0, bus.inflight}, 32'd1);
    @(negedge clk);
    chk("single st one cycle", {31'd0, bus.req_st}, 32'd0);
    wait_res();
    // ARM, 20 busy WAIT cycles, 1 idle WAIT cycle, CAPTURE, then visible
    chk("single latency", cyc - st_cyc, 32'd22);
    chk("single inflight drop", {31'd0, bus.inflight}, 32'd0);
    pop_expect("single", 32'd7, 1'b0);
    chk("single st count", st_log.size() - base, 32'd1);

    // burst: 10, 20, 45 with out = in*3
    rsp_lat = 5; rsp_mul = 32'd3; rsp_add = 32'd0;
    base = st_log.size();
    push_op(16'd10, w); chk("burst ready 0", w, 32'd0);
    push_op(16'd20, w); chk("burst ready 1", w, 32'd0);
    push_op(16'd45, w); chk("burst ready 2", w, 32'd0);
    pop_expect("burst 0", 32'd30, 1'b0);
    pop_expect("burst 1", 32'd60, 1'b0);
    pop_expect("burst 2", 32'd135, 1'b0);
    chk("burst st count", st_log.size() - base, 32'd3);
    chk("burst st0", {16'd0, st_log[base]}, 32'd10);
    chk("burst st1", {16'd0, st_log[base+1]}, 32'd20);
    chk("burst st2", {16'd0, st_log[base+2]}, 32'd45);

    // backpressure: consumer stalled, 6 ops, out = in + 100
    rsp_lat = 3; rsp_mul = 32'd1; rsp_add = 32'd100;
    base = st_log.size();
    for (int i = 1; i <= 6; i++) push_op(16'(i), w);
    repeat (100) @(negedge clk);
    chk("bp launches while full", st_log.size() - base, 32'd4);
    chk("bp op_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("bp inflight idle", {31'd0, bus.inflight}, 32'd0);
    for (int i = 1; i <= 6; i++) pop_expect("bp", 32'(100 + i), 1'b0);
    chk("bp total launches", st_log.size() - base, 32'd6);

    // operand FIFO full: busy 40 cycles, out = in*2
    rsp_lat = 40; rsp_mul = 32'd2; rsp_add = 32'd0;
    for (int i = 11; i <= 15; i++) push_op(16'(i), w);
    chk("full op_ready low", {31'd0, bus.op_ready}, 32'd0);
    bus.op_valid = 1'b1;
    bus.op_data  = 16'd16;
    repeat (20) @(negedge clk);
    chk("full still held", {31'd0, bus.op_ready}, 32'd0);
    push_op(16'd16, w);
    for (int i = 11; i <= 16; i++) pop_expect("full", 32'(2 * i), 1'b0);

    // reset during WAIT abandons the request
    rsp_lat = 30; rsp_mul = 32'd0; rsp_add = 32'd99;
    push_op(16'd3, w);
    repeat (10) @(negedge clk);
    chk("mid inflight before rst", {31'd0, bus.inflight}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid reset");
    rst = 1'b0;
    base = st_log.size();
    repeat (40) @(negedge clk);
    chk("mid no result", {31'd0, bus.res_valid}, 32'd0);
    chk("mid no relaunch", st_log.size() - base, 32'd0);
    rsp_lat = 4; rsp_mul = 32'd1; rsp_add = 32'd0;
    push_op(16'd5, w);
    pop_expect("after reset", 32'd5, 1'b0);
    chk("no double st", dbl_st, 32'd0);
    chk("no st while busy", ovl, 32'd0);

`ifdef WATCHDOG_EN
    // core never drops busy: timeout result, then next op launches
    rsp_hold = 1'b1;
    push_op(16'd7, w);
    wait_res();
    // ARM, 50 WAIT cycles, CAPTURE, then visible
    chk("wd latency", cyc - st_cyc, 32'd51);
    pop_expect("watchdog", 32'hFFFF_FFFF, 1'b1);
    base = st_log.size();
    push_op(16'd8, w);
    t = 0;
    while (st_log.size() == base && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wd next launch", st_log.size() - base, 32'd1);
    chk("wd next req_in", {16'd0, bus.req_in}, 32'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
